alu_mul_seq: RTL

- Multi-cycle unsigned 32x32->64 shift-add multiplier sequencer that time-shares the existing 32-bit ALU; it adds no adder of its own.
- Requests the ALU through a req/gnt pair. The CPU-side ALU input mux selects this block's operands while alu_gnt_i=1.
- Each multiplier bit uses two ALU operations: ADD (partial sum), then unsigned set-less-than to recover the carry-out, which the ALU does not export.
- Sits beside the single-cycle datapath as the execution engine for MULTU-style instructions.

---
 rtl/alu_mul_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 shift-add multiplier that borrows the shared 32-bit ALU for every add and carry recovery.
// Optional macro ALU_MUL_ZERO_SKIP_EN: shift zero multiplier bits locally without requesting the ALU.
module alu_mul_seq #(
  parameter logic [3:0]  CTRL_ADD = 4'b0010,
  parameter logic [3:0]  CTRL_CMP = 4'b1000,
  parameter int unsigned ITER     = 32
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] mcand_i,
  input  logic [31:0] mplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] prod_hi_o,
  output logic [31:0] prod_lo_o,
  output logic        alu_req_o,
  input  logic        alu_gnt_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_CARRY,
    S_DONE
  } state_e;

  localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] sum_q, sum_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        skip_bit;

`ifdef ALU_MUL_ZERO_SKIP_EN
  assign skip_bit = ~lo_q[0];
`else
  assign skip_bit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    done_o     = 1'b0;
    alu_req_o  = 1'b0;
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = CTRL_ADD;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d = mcand_i;
          lo_d    = mplier_i;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        if (skip_bit) begin
          hi_d    = {1'b0, hi_q[31:1]};
          lo_d    = {hi_q[0], lo_q[31:1]};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
        end else begin
          alu_req_o  = 1'b1;
          alu_src1_o = hi_q;
          alu_src2_o = lo_q[0] ? mcand_q : 32'd0;
          alu_ctrl_o = CTRL_ADD;
          if (alu_gnt_i) begin
            sum_d   = alu_result_i;
            state_d = S_CARRY;
          end
        end
      end

      S_CARRY: begin
        // sum < hi (unsigned) exactly when the preceding add carried out of bit 31.
        alu_req_o  = 1'b1;
        alu_src1_o = sum_q;
        alu_src2_o = hi_q;
        alu_ctrl_o = CTRL_CMP;
        if (alu_gnt_i) begin
          hi_d    = {alu_result_i[0], sum_q[31:1]};
          lo_d    = {sum_q[0], lo_q[31:1]};
          cnt_d   = cnt_q + 5'd1;
          state_d = (cnt_q == CNT_LAST) ? S_DONE : S_ADD;
        end
      end

      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign prod_hi_o = hi_q;
  assign prod_lo_o = lo_q;

endmodule
